// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Pure declarations: no latency, no handshake.
package imem_program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WORD_BYTES         = 4;
  localparam int DEFAULT_ADDR_WIDTH = 6;

endpackage

// File: rtl/imem_program_loader_byte_word_assembler.sv
// Shifts bytes MSB-first into a 32-bit word; word_full flags the 4th accepted byte.
// Word updates on the accepting edge; upstream handshake is owned by the caller via shift_en.
module imem_program_loader_byte_word_assembler
  import imem_program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0] byte_cnt;

  assign word_full = shift_en && !clear && (byte_cnt == LAST_BYTE);

  // clear beats shift so an aborted partial word never completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], byte_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a byte-streamed program into instruction memory from word 0, stalling the CPU throughout.
// Per word: 4 RECV cycles + 1 WRITE; byte_ready drops in WRITE/DONE so the source holds its byte.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len_words,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_stall,
  output logic                  pc_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  word_full;
  logic                  last_word;
  logic                  len_ok;

  assign byte_ready = (state == RECV);
  assign busy       = (state != IDLE);
  assign cpu_stall  = busy;
  assign mem_we     = (state == WRITE) && !abort;
  assign mem_addr   = {{(30-ADDR_WIDTH){1'b0}}, word_idx, 2'b00};
  assign last_word  = ({1'b0, word_idx} == (len - (ADDR_WIDTH+1)'(1)));
  assign len_ok     = (len_words != '0) && (len_words <= DEPTH);

  imem_program_loader_byte_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     ((state == IDLE) || abort),
    .shift_en  (byte_valid && byte_ready),
    .byte_data (byte_data),
    .word      (mem_wdata),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len      <= '0;
      word_idx <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      pc_reset <= 1'b0;
    end else begin
      err      <= 1'b0;
      done     <= 1'b0;
      pc_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len      <= len_words;
              word_idx <= '0;
              state    <= RECV;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (word_full) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (last_word) begin
            state <= DONE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= RECV;
          end
        end
        DONE: begin
          // completion pulses are registered, so an abort here can still cancel them
          if (abort) begin
            err <= 1'b1;
          end else begin
            done     <= 1'b1;
            pc_reset <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
